cp0_timer: RTL and testbench
============================

# cp0_timer

Parametrised coprocessor-0 for the pipelined MIPS core. It holds the SR, Cause and EPC exception registers, plus a Count/Compare timer with a programmable prescaler, a BadVAddr register and a read-only PRId. It sits beside the M stage: it takes exception codes and interrupt lines, raises `Req` to flush the pipeline, and supplies `EPCOut` to the fetch stage on `eret`.

## Interface
- `HWINT_W`, default 6: number of external interrupt lines, legal 1..6, mapped onto IP[10+HWINT_W-1:10].
- `COUNT_DIV`, default 1: Count increments once every `COUNT_DIV` cycles, legal ≥1.
- `PRID`, default 32'h0000_4C43: constant returned for register 15.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  mtc0 write strobe.
- BDIn  in  1  faulting instruction is in a delay slot.
- EXLClr  in  1  eret; clears SR.EXL.
- CP0Add  in  5  register select for read and write.
- ExcCodeIn  in  5  exception code from the pipeline; 0 means none.
- HWInt  in  HWINT_W  external interrupt levels.
- CP0In  in  32  mtc0 data.
- vpc  in  32  PC of the M-stage instruction.
- BadVAddrIn  in  32  faulting data/instruction address.
- Req  out  1  take exception/interrupt this cycle.
- CP0Out  out  32  mfc0 read data.
- EPCOut  out  32  return/victim PC.
- TimerIrq  out  1  registered timer-interrupt flag, Cause.TI.

## Operation
- Field map:
  - SR: IM[15:10], EXL[1], IE[0]. All other SR bits read as 0.
  - Cause: BD[31], TI[30], IP[15:10], ExcCode[6:2]. Other Cause bits read as 0.
- Pending vector P[5:0] = zero-extended HWInt, with P[5] OR'd with TI.
- Request logic:
  - `exception` = !EXL && |ExcCodeIn.
  - `interrupt` = !EXL && IE && |(P & IM).
  - Req = exception | interrupt. This is combinational.
- EPCOut = Req ? (BDIn ? vpc−4 : vpc) : EPC.
- Every cycle, Cause.IP is loaded with P.
- On Req:
  - ExcCode ← interrupt ? 0 : ExcCodeIn. Interrupt wins over a simultaneous exception.
  - EXL ← 1, EPC ← EPCOut, BD ← BDIn.
  - If !interrupt and ExcCodeIn ∈ {4, 5}, BadVAddr ← BadVAddrIn.
- EXLClr clears EXL. If Req is asserted in the same cycle, Req wins and EXL ends at 1.
- mtc0 (en=1, Req=0):
  - 12 writes SR.
  - 14 writes EPC.
  - 9 writes Count and zeroes the prescaler.
  - 11 writes Compare and clears TI.
  - Writes to 8, 13 and 15 are ignored.
  - Any write is suppressed when Req=1.
- Reads (CP0Out):
  - 8 returns BadVAddr; 9 returns Count; 11 returns Compare.
  - 12 returns SR; 13 returns Cause; 15 returns PRID.
  - 14 returns EPCOut, so a read during Req shows the new victim PC.
  - Any other address returns 0.
- Timer:
  - A prescaler counts 0..COUNT_DIV−1. `tick` is asserted when it equals COUNT_DIV−1, and the prescaler then wraps to 0.
  - On `tick`, Count ← Count+1 modulo 2^32 (FFFF_FFFF wraps to 0).
  - If a tick occurs and Count+1 == Compare, TI ← 1. TI is sticky until a Compare write or reset.
- Same-cycle conflicts:
  - mtc0 Count beats a tick; no match check happens that cycle.
  - mtc0 Compare beats a match; TI ends at 0.
  - Count continues to run while EXL=1.

## Timing
- Reset values:
  - SR = 0, Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, prescaler = 0.
  - Compare = FFFF_FFFF, TI = 0, TimerIrq = 0.
- During reset, Req = |ExcCodeIn, because EXL=0 and IE=0. EPCOut follows Req.
- Req, EPCOut and CP0Out are same-cycle combinational; all register effects are visible after the next edge.
- If a match occurs at edge N, TI=1 after edge N. Req can assert in cycle N+1 (provided IE=1, IM[15]=1, EXL=0).
- After mtc0 Count at edge N, the first increment lands at edge N+COUNT_DIV.
- CP0Out of Count shows the pre-edge register value; there is no write bypass.
- Reset is asynchronous mid-operation: it clears EXL and TI at once, and Req drops immediately unless ExcCodeIn≠0.

## Test plan
- Reset, then SR=0x0000_0401 (IM[10], IE), then HWInt=1 → Req=1 that cycle, EPCOut=vpc, and after the edge Cause.ExcCode=0, EXL=1, IP[10]=1.
- With IE=0, apply ExcCodeIn=4, BDIn=1, vpc=0x3008, BadVAddrIn=0x1233 → Req=1, EPCOut=0x3004, and after the edge BD=1, ExcCode=4, BadVAddr=0x1233. Then assert EXLClr → EXL=0.
- With COUNT_DIV=4, write Count=0 and Compare=3 → Count reaches 3 after 12 cycles, TI/TimerIrq rise on that edge, and Req rises the next cycle with SR=0x0000_8001. A Compare write then → TI=0.
- Write Count=FFFF_FFFF with COUNT_DIV=1 → the next edge gives Count=0. With Compare=0, TI=1.
- In the same cycle apply a Compare write and a Count+1==Compare match → TI=0. In another cycle apply EXLClr and Req together → EXL=1 and EPC is updated.
- Assert reset asynchronously with EXL=1, TI=1, Count=0x55 → all registers return to reset values before the next clk edge, and Req=0.

Source files
------------

// File: rtl/cp0_timer.sv
// Coprocessor 0: SR/Cause/EPC exception state, BadVAddr, PRId and a
// prescaled Count/Compare timer that can raise a hardware interrupt.
module cp0_timer #(
    parameter int          HWINT_W   = 6,
    parameter int          COUNT_DIV = 1,
    parameter logic [31:0] PRID      = 32'h0000_4C43
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               BDIn,
    input  logic               EXLClr,
    input  logic [4:0]         CP0Add,
    input  logic [4:0]         ExcCodeIn,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic [31:0]        CP0In,
    input  logic [31:0]        vpc,
    input  logic [31:0]        BadVAddrIn,
    output logic               Req,
    output logic [31:0]        CP0Out,
    output logic [31:0]        EPCOut,
    output logic               TimerIrq
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

    localparam logic [4:0] A_BADV  = 5'd8;
    localparam logic [4:0] A_COUNT = 5'd9;
    localparam logic [4:0] A_CMP   = 5'd11;
    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [5:0]    im;
    logic          exl;
    logic          ie;
    logic          bd;
    logic          ti;
    logic [5:0]    ip;
    logic [4:0]    exccode;
    logic [31:0]   epc;
    logic [31:0]   badvaddr;
    logic [31:0]   count;
    logic [31:0]   compare;
    logic [PW-1:0] presc;

    logic [5:0]    pend;
    logic          exception;
    logic          interrupt;
    logic          wr;
    logic          wr_sr;
    logic          wr_epc;
    logic          wr_count;
    logic          wr_cmp;
    logic          tick;
    logic          match;
    logic          bad_load;
    logic [31:0]   count_inc;
    logic [31:0]   sr_val;
    logic [31:0]   cause_val;

    // Timer interrupt shares the top line with HWInt[5].
    always_comb begin
        pend = '0;
        pend[HWINT_W-1:0] = HWInt;
        pend[5] = pend[5] | ti;
    end

    assign exception = !exl && (ExcCodeIn != 5'd0);
    assign interrupt = !exl && ie && ((pend & im) != 6'd0);
    assign Req       = exception | interrupt;

    assign EPCOut = Req ? (BDIn ? vpc - 32'd4 : vpc) : epc;

    assign wr       = en && !Req;
    assign wr_sr    = wr && (CP0Add == A_SR);
    assign wr_epc   = wr && (CP0Add == A_EPC);
    assign wr_count = wr && (CP0Add == A_COUNT);
    assign wr_cmp   = wr && (CP0Add == A_CMP);

    assign tick      = (presc == PMAX);
    assign count_inc = count + 32'd1;
    assign match     = tick && !wr_count && (count_inc == compare);

    assign bad_load = Req && !interrupt &&
                      ((ExcCodeIn == 5'd4) || (ExcCodeIn == 5'd5));

    assign TimerIrq = ti;

    assign sr_val    = {16'd0, im, 8'd0, exl, ie};
    assign cause_val = {bd, ti, 14'd0, ip, 3'd0, exccode, 2'd0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im  <= '0;
            ie  <= 1'b0;
            exl <= 1'b0;
        end else begin
            if (wr_sr) begin
                im <= CP0In[15:10];
                ie <= CP0In[0];
            end
            if (Req)
                exl <= 1'b1;
            else if (EXLClr)
                exl <= 1'b0;
            else if (wr_sr)
                exl <= CP0In[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip      <= '0;
            bd      <= 1'b0;
            exccode <= '0;
        end else begin
            ip <= pend;
            if (Req) begin
                bd      <= BDIn;
                exccode <= interrupt ? 5'd0 : ExcCodeIn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            if (Req)
                epc <= EPCOut;
            else if (wr_epc)
                epc <= CP0In;
            if (bad_load)
                badvaddr <= BadVAddrIn;
        end
    end

    // A Count write restarts the prescaler so the next increment is a
    // full COUNT_DIV cycles away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            count <= '0;
        end else if (wr_count) begin
            presc <= '0;
            count <= CP0In;
        end else if (tick) begin
            presc <= '0;
            count <= count_inc;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare <= 32'hFFFF_FFFF;
            ti      <= 1'b0;
        end else if (wr_cmp) begin
            compare <= CP0In;
            ti      <= 1'b0;
        end else if (match) begin
            ti <= 1'b1;
        end
    end

    always_comb begin
        CP0Out = 32'd0;
        unique case (CP0Add)
            A_BADV:  CP0Out = badvaddr;
            A_COUNT: CP0Out = count;
            A_CMP:   CP0Out = compare;
            A_SR:    CP0Out = sr_val;
            A_CAUSE: CP0Out = cause_val;
            A_EPC:   CP0Out = EPCOut;
            A_PRID:  CP0Out = PRID;
            default: CP0Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_timer.sv
// Bench for cp0_timer: directed scenarios plus random traffic, with a
// register-level reference model feeding a scoreboard queue.
module tb_cp0_timer;

    localparam int DIV = 4;
    localparam logic [31:0] PRID = 32'h0000_4C43;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        BDIn = 1'b0;
    logic        EXLClr = 1'b0;
    logic [4:0]  CP0Add = '0;
    logic [4:0]  ExcCodeIn = '0;
    logic [5:0]  HWInt = '0;
    logic [31:0] CP0In = '0;
    logic [31:0] vpc = '0;
    logic [31:0] BadVAddrIn = '0;
    logic        Req;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        TimerIrq;

    cp0_timer #(.HWINT_W(6), .COUNT_DIV(DIV), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .en(en), .BDIn(BDIn),
        .EXLClr(EXLClr), .CP0Add(CP0Add), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .CP0In(CP0In), .vpc(vpc),
        .BadVAddrIn(BadVAddrIn), .Req(Req), .CP0Out(CP0Out),
        .EPCOut(EPCOut), .TimerIrq(TimerIrq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        req;
        logic [31:0] epc;
        logic [31:0] rd;
        logic        ti;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Architectural state of the model, held as whole 32-bit registers.
    logic [31:0] s_sr, s_cause, s_epc, s_bad, s_cnt, s_cmp;
    logic [31:0] n_sr, n_cause, n_epc, n_bad, n_cnt, n_cmp;
    int s_since, n_since;
    logic cur_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        s_sr = 0; s_cause = 0; s_epc = 0; s_bad = 0;
        s_cnt = 0; s_cmp = 32'hFFFF_FFFF; s_since = 0;
    endtask

    task automatic eval(output exp_t e);
        logic [5:0] p;
        logic ex, it, rq, wr, tick, cwr, ti_c;
        ti_c = s_cause[30];
        p = HWInt | (ti_c ? 6'h20 : 6'h00);
        ex = !s_sr[1] && (ExcCodeIn != 0);
        it = !s_sr[1] && s_sr[0] && ((p & s_sr[15:10]) != 0);
        rq = ex || it;
        e.addr = CP0Add;
        e.req = rq;
        e.ti = ti_c;
        e.epc = rq ? (BDIn ? vpc - 4 : vpc) : s_epc;
        case (CP0Add)
            5'd8:  e.rd = s_bad;
            5'd9:  e.rd = s_cnt;
            5'd11: e.rd = s_cmp;
            5'd12: e.rd = s_sr;
            5'd13: e.rd = s_cause;
            5'd14: e.rd = e.epc;
            5'd15: e.rd = PRID;
            default: e.rd = 0;
        endcase
        wr = en && !rq;
        tick = (s_since % DIV) == DIV - 1;
        cwr = wr && CP0Add == 9;
        n_sr = s_sr; n_cause = s_cause; n_epc = s_epc;
        n_bad = s_bad; n_cnt = s_cnt; n_cmp = s_cmp;
        n_cause = (s_cause & ~32'h0000_FC00) | (32'(p) << 10);
        if (rq) begin
            n_cause[31] = BDIn;
            n_cause[6:2] = it ? 5'd0 : ExcCodeIn;
        end
        if (tick && !cwr && s_cnt + 1 == s_cmp) n_cause[30] = 1'b1;
        if (wr && CP0Add == 11) begin
            n_cause[30] = 1'b0;
            n_cmp = CP0In;
        end
        if (cwr) begin
            n_cnt = CP0In;
            n_since = 0;
        end else begin
            n_since = s_since + 1;
            if (tick) n_cnt = s_cnt + 1;
        end
        if (wr && CP0Add == 12) n_sr = CP0In & 32'h0000_FC03;
        if (rq) n_sr[1] = 1'b1;
        else if (EXLClr) n_sr[1] = 1'b0;
        if (rq) n_epc = e.epc;
        else if (wr && CP0Add == 14) n_epc = CP0In;
        if (rq && !it && (ExcCodeIn == 4 || ExcCodeIn == 5))
            n_bad = BadVAddrIn;
    endtask

    task automatic step(input logic r, input logic e, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] x,
                        input logic [5:0] h, input logic b,
                        input logic c, input logic [31:0] pc,
                        input logic [31:0] bv);
        exp_t ex;
        @(posedge clk);
        if (cur_rst) model_reset();
        else begin
            s_sr = n_sr; s_cause = n_cause; s_epc = n_epc;
            s_bad = n_bad; s_cnt = n_cnt; s_cmp = n_cmp;
            s_since = n_since;
        end
        #1;
        reset = r; en = e; CP0Add = a; CP0In = d; ExcCodeIn = x;
        HWInt = h; BDIn = b; EXLClr = c; vpc = pc; BadVAddrIn = bv;
        cur_rst = r;
        if (r) model_reset();
        eval(ex);
        q.push_back(ex);
    endtask

    task automatic idle(input logic [4:0] a);
        step(0, 0, a, 0, 0, 0, 0, 0, 32'h100, 0);
    endtask

    task automatic wrreg(input logic [4:0] a, input logic [31:0] d);
        step(0, 1, a, d, 0, 0, 0, 0, 32'h100, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("Req", 32'(Req), 32'(e.req));
            chk("EPCOut", EPCOut, e.epc);
            chk($sformatf("CP0Out[%0d]", e.addr), CP0Out, e.rd);
            chk("TimerIrq", 32'(TimerIrq), 32'(e.ti));
        end
    end

    initial begin
        model_reset();
        step(1, 0, 12, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 15, 0, 3, 0, 0, 0, 32'h40, 0);
        idle(11);
        // Hardware interrupt on IP[10].
        wrreg(12, 32'h0000_0401);
        step(0, 0, 13, 0, 0, 6'h01, 0, 0, 32'h2000, 0);
        idle(13);
        idle(12);
        idle(14);
        // Address error in a delay slot with interrupts off.
        wrreg(12, 32'h0);
        step(0, 0, 14, 0, 4, 0, 1, 0, 32'h3008, 32'h1233);
        idle(13);
        idle(8);
        step(0, 0, 12, 0, 0, 0, 0, 1, 32'h100, 0);
        idle(12);
        // Timer interrupt through IM[15].
        wrreg(12, 32'h0000_8001);
        wrreg(11, 3);
        wrreg(9, 0);
        for (int i = 0; i < 13; i++) idle(9);
        idle(13);
        idle(12);
        wrreg(11, 32'h1000);
        idle(13);
        // Count wrap onto Compare = 0.
        wrreg(12, 0);
        wrreg(11, 0);
        wrreg(9, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) idle(9);
        idle(13);
        // Compare write in the same cycle as a match.
        wrreg(11, 2);
        wrreg(9, 0);
        for (int i = 0; i < 7; i++) idle(9);
        wrreg(11, 32'h100);
        idle(13);
        idle(9);
        // EXLClr together with an exception.
        step(0, 0, 14, 0, 8, 0, 0, 1, 32'h4444, 0);
        idle(12);
        idle(14);
        // Async reset with EXL, TI and Count all non-zero.
        wrreg(12, 0);
        wrreg(11, 32'h55);
        wrreg(9, 32'h54);
        for (int i = 0; i < 4; i++) idle(9);
        step(0, 0, 13, 0, 2, 0, 0, 0, 32'h500, 0);
        idle(12);
        step(1, 0, 9, 0, 0, 0, 0, 0, 32'h600, 0);
        step(1, 0, 13, 0, 0, 0, 0, 0, 32'h600, 0);
        step(1, 0, 11, 0, 6, 0, 0, 0, 32'h604, 0);
        idle(12);
        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            logic e, b, c;
            logic [4:0] a, x;
            logic [5:0] h;
            logic [31:0] d;
            int sel;
            e = ($urandom_range(0, 3) == 0);
            a = 5'($urandom_range(0, 31));
            if (e || $urandom_range(0, 1) == 0) begin
                sel = $urandom_range(0, 6);
                case (sel)
                    0: a = 8;  1: a = 9;  2: a = 11;  3: a = 12;
                    4: a = 13; 5: a = 14; default: a = 15;
                endcase
            end
            d = $urandom;
            if (a == 9 && e) d = s_cmp - 32'($urandom_range(1, 3));
            if (a == 12 && e && $urandom_range(0, 1) == 0) d[1] = 1'b0;
            x = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31))
                                            : 5'd0;
            if ($urandom_range(0, 5) == 0) x = 5'($urandom_range(4, 5));
            if ($urandom_range(0, 1) == 0) x = 0;
            h = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            b = 1'($urandom);
            c = !e && ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 199) == 0), e, a, d, x, h, b, c,
                 {$urandom} & 32'hFFFF_FFFC, $urandom);
        end
        idle(0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
